sort_verify: RTL and testbench

Post-sort result checker that sits directly downstream of `bubble_sort` on the shared 256×8 on-chip memory. Once the top-level FSM reaches DONE, it hands the memory port to this block and pulses `enable`. The block streams addresses 0..len-1 at one element per cycle and reports the following, all held until the next run:

- whether the data is non-decreasing;
- the index of the first inversion;
- the minimum and maximum values;
- optionally, a checksum.

It reuses the `bubble_sort` enable/ready handshake so the top-level FSM drives both blocks the same way.

---
 rtl/sort_pkg.sv | 24 ++
 rtl/sort_verify.sv | 119 +++++++++++
 tb/tb_sort_verify.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared widths, verifier state encoding and length clamp for the sort/verify datapath.
package sort_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int LEN_W     = 10;
    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = 9;   // holds 0..MEM_DEPTH inclusive

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SCAN   = 2'd2,
        FINISH = 2'd3
    } verify_state_t;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MEM_DEPTH))
            return CNT_W'(MEM_DEPTH);
        else
            return len[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sort_verify.sv
// Post-sort checker: streams memory 0..len-1, reports order, first inversion, min/max.
// Optional checksum port and adder are built only when SORT_VERIFY_CHECKSUM_EN is defined.
module sort_verify
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              ready,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic              sorted,
    output logic [ADDR_W-1:0] err_index,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
`ifdef SORT_VERIFY_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    verify_state_t     state;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  k;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
    logic              acc_sorted;
    logic [ADDR_W-1:0] acc_err;
    logic              last_elem;
    logic              inversion;

    assign ready     = (state == IDLE);
    assign last_elem = (k == n - CNT_W'(1));
    // k==0 has no predecessor; only the first inversion is recorded
    assign inversion = (k != '0) && acc_sorted && (rdata < prev);

`ifdef SORT_VERIFY_CHECKSUM_EN
    logic [15:0] acc_sum;
`endif

    // rdata reflects the address register one cycle after it is loaded, so
    // FETCH already sees element 0 and shares the scan step with SCAN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            n          <= '0;
            k          <= '0;
            prev       <= '0;
            acc_min    <= '1;
            acc_max    <= '0;
            acc_sorted <= 1'b1;
            acc_err    <= '0;
            address    <= '0;
            sorted     <= 1'b1;
            err_index  <= '0;
            min_val    <= '0;
            max_val    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        n          <= clamp_len(length);
                        k          <= '0;
                        acc_sorted <= 1'b1;
                        acc_err    <= '0;
                        acc_min    <= '1;
                        acc_max    <= '0;
                        address    <= '0;
                        state      <= (clamp_len(length) == '0) ? FINISH : FETCH;
                    end
                end
                FETCH, SCAN: begin
                    if (rdata < acc_min) acc_min <= rdata;
                    if (rdata > acc_max) acc_max <= rdata;
                    if (inversion) begin
                        acc_sorted <= 1'b0;
                        acc_err    <= k[ADDR_W-1:0];
                    end
                    prev <= rdata;
                    k    <= k + CNT_W'(1);
                    // stop at n-1 so the address never wraps past 255
                    if (last_elem) begin
                        state <= FINISH;
                    end else begin
                        address <= address + ADDR_W'(1);
                        state   <= SCAN;
                    end
                end
                FINISH: begin
                    sorted    <= acc_sorted;
                    err_index <= acc_err;
                    min_val   <= (n == '0) ? '0 : acc_min;
                    max_val   <= (n == '0) ? '0 : acc_max;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORT_VERIFY_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_sum  <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE:        if (enable) acc_sum <= '0;
                FETCH, SCAN: acc_sum <= acc_sum + {8'd0, rdata};
                FINISH:      checksum <= acc_sum;
                default:     ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sort_verify.sv
// Randomized scoreboard bench for sort_verify with a behavioural memory and reference model.
module tb_sort_verify;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       ready;
    logic [9:0] length;
    logic [7:0] rdata;
    logic [7:0] address;
    logic       sorted;
    logic [7:0] err_index;
    logic [7:0] min_val;
    logic [7:0] max_val;
`ifdef SORT_VERIFY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0] mem [256];

    typedef struct {
        bit  sorted;
        int  err;
        int  mn;
        int  mx;
        int  sum;
        int  addr;
        int  low;
        bit  chk_low;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    sort_verify dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ready     (ready),
        .length    (length),
        .rdata     (rdata),
        .address   (address),
        .sorted    (sorted),
        .err_index (err_index),
        .min_val   (min_val),
        .max_val   (max_val)
`ifdef SORT_VERIFY_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Memory q follows the registered address (1-cycle latency from the address load edge)
    assign rdata = mem[address];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model straight from the result definitions
    function automatic exp_t model(input int len);
        exp_t e;
        int n;
        n = (len > 256) ? 256 : len;
        e.sorted = 1; e.err = 0; e.sum = 0; e.chk_low = 1;
        e.mn = (n > 0) ? 255 : 0;
        e.mx = 0;
        for (int i = 0; i < n; i++) begin
            if (mem[i] < e.mn) e.mn = mem[i];
            if (mem[i] > e.mx) e.mx = mem[i];
            e.sum = (e.sum + mem[i]) % 65536;
            if (i > 0 && e.sorted && mem[i] < mem[i-1]) begin
                e.sorted = 0;
                e.err    = i;
            end
        end
        e.addr = (n > 0) ? n - 1 : 0;
        e.low  = n + 1;
        return e;
    endfunction

    // Monitor: on every rising ready, pop the oldest expectation and compare
    int  low_cnt  = 0;
    int  max_addr = 0;
    bit  prev_rdy = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b0) begin
            low_cnt++;
            if (int'(address) > max_addr) max_addr = int'(address);
        end
        if (ready === 1'b1 && !prev_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got result with empty queue, expected none");
            end else begin
                e = sb.pop_front();
                chk("sorted",    int'(sorted),    int'(e.sorted));
                chk("err_index", int'(err_index), e.err);
                chk("min_val",   int'(min_val),   e.mn);
                chk("max_val",   int'(max_val),   e.mx);
                chk("address",   int'(address),   e.addr);
`ifdef SORT_VERIFY_CHECKSUM_EN
                chk("checksum",  int'(checksum),  e.sum);
`endif
                if (e.chk_low) begin
                    chk("ready_low_cycles", low_cnt,  e.low);
                    chk("max_address",      max_addr, e.addr);
                end
            end
            low_cnt  = 0;
            max_addr = 0;
        end
        prev_rdy = (ready === 1'b1);
    end

    task automatic run(input int len, input bit noise);
        int guard;
        sb.push_back(model(len));
        @(negedge clk);
        enable = 1'b1;
        length = 10'(len);
        @(negedge clk);
        enable = 1'b0;
        length = 10'($urandom);
        guard  = 0;
        while (ready !== 1'b1 && guard < 2000) begin
            // ready is still low here, so any enable pulse must be ignored
            if (noise) begin
                enable = 1'($urandom_range(0, 1));
                length = 10'($urandom_range(0, 20));
            end
            @(negedge clk);
            if (ready === 1'b1) enable = 1'b0;
            guard++;
        end
        enable = 1'b0;
        if (guard >= 2000) begin
            checks++;
            $display("FAIL run_timeout: ready still %b after %0d cycles, expected 1", ready, guard);
        end
    endtask

    task automatic load(input int vals[], input int cnt);
        for (int i = 0; i < cnt; i++) mem[i] = 8'(vals[i]);
    endtask

    initial begin
        int guard;
        exp_t r;
        rst_n  = 1'b0;
        enable = 1'b0;
        length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_ready",     int'(ready),     1);
        chk("rst_address",   int'(address),   0);
        chk("rst_sorted",    int'(sorted),    1);
        chk("rst_err_index", int'(err_index), 0);
        chk("rst_min",       int'(min_val),   0);
        chk("rst_max",       int'(max_val),   0);
`ifdef SORT_VERIFY_CHECKSUM_EN
        chk("rst_checksum",  int'(checksum),  0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        load('{1, 2, 3, 3, 9}, 5);
        run(5, 0);
        load('{4, 7, 2, 8, 1}, 5);
        run(5, 0);
        run(0, 0);
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        run(1023, 0);
        run(256, 0);
        run(1, 0);

        // Reset in the middle of a length-10 run: outputs must return to reset values
        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom);
        r = '{sorted: 1, err: 0, mn: 0, mx: 0, sum: 0, addr: 0, low: 0, chk_low: 0};
        sb.push_back(r);
        @(negedge clk);
        enable = 1'b1;
        length = 10'd10;
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load('{9, 3}, 2);
        run(2, 0);

        // Enable noise during runs must not disturb results or run length
        load('{4, 7, 2, 8, 1}, 5);
        run(5, 1);
        for (int t = 0; t < 24; t++) begin
            int len;
            len = (t % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
            if (t % 3 == 0) begin
                mem[0] = 8'($urandom_range(0, 20));
                for (int i = 1; i < 256; i++)
                    mem[i] = (mem[i-1] > 8'd250) ? mem[i-1] : mem[i-1] + 8'($urandom_range(0, 3));
                if (t % 2 == 0) mem[$urandom_range(1, 30)] = 8'($urandom);
            end else begin
                for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            end
            run(len, t[0]);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
